// File: rtl/axi_pkg.sv
// axi_pkg: AXI4 channel widths, packed channel payloads and slice configuration types.
// xLAST sits at bit 0 of the channels that carry it; -1 marks channels without LAST.
package axi_pkg;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_REG_W   = 4;
    localparam int AXI_DATA_W  = 32;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_LOCK_W  = 1;
    localparam int AXI_CACHE_W = 4;
    localparam int AXI_PROT_W  = 3;
    localparam int AXI_QOS_W   = 4;
    localparam int AXI_STRB_W  = 4;
    localparam int AXI_RESP_W  = 2;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [AXI_LOCK_W-1:0]  lock;
        logic [AXI_CACHE_W-1:0] cache;
        logic [AXI_PROT_W-1:0]  prot;
        logic [AXI_QOS_W-1:0]   qos;
        logic [AXI_REG_W-1:0]   region;
    } aw_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]    id;
        logic [AXI_ADDR_W-1:0]  addr;
        logic [AXI_LEN_W-1:0]   len;
        logic [AXI_SIZE_W-1:0]  size;
        logic [AXI_BURST_W-1:0] burst;
        logic [AXI_LOCK_W-1:0]  lock;
        logic [AXI_CACHE_W-1:0] cache;
        logic [AXI_PROT_W-1:0]  prot;
        logic [AXI_QOS_W-1:0]   qos;
        logic [AXI_REG_W-1:0]   region;
    } ar_chan_t;

    typedef struct packed {
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_STRB_W-1:0] strb;
        logic                  last;
    } w_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_RESP_W-1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [AXI_ID_W-1:0]   id;
        logic [AXI_DATA_W-1:0] data;
        logic [AXI_RESP_W-1:0] resp;
        logic                  last;
    } r_chan_t;

    localparam int AW_LAST_BIT = -1;
    localparam int W_LAST_BIT  = 0;
    localparam int B_LAST_BIT  = -1;
    localparam int AR_LAST_BIT = -1;
    localparam int R_LAST_BIT  = 0;

    typedef enum logic [1:0] {SLICE_BYPASS, SLICE_FWD, SLICE_SKID, SLICE_FIFO} slice_mode_e;
    typedef enum logic {FWD_EMPTY, FWD_FULL} fwd_state_e;
    typedef enum logic [1:0] {SKID_EMPTY, SKID_ONE, SKID_TWO} skid_state_e;
endpackage

// File: rtl/axi_chan_fifo.sv
// axi_chan_fifo: show-ahead circular buffer with registered head output.
// Pointers carry one extra MSB so full and empty are distinguishable.
module axi_chan_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [W-1:0]  s_data_i,
    input  logic          s_valid_i,
    output logic          s_ready_o,
    output logic [W-1:0]  m_data_o,
    output logic          m_valid_o,
    input  logic          m_ready_i,
    output logic [AW:0]   occ_o
);
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] head_q, head_d;
    logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic         rdy_q, full, push, pop;

    assign full      = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
    assign m_valid_o = wptr_q != rptr_q;
    assign s_ready_o = rdy_q && !full;
    assign push      = s_valid_i && s_ready_o;
    assign pop       = m_valid_o && m_ready_i;
    assign wptr_d    = wptr_q + {{AW{1'b0}}, push};
    assign rptr_d    = rptr_q + {{AW{1'b0}}, pop};
    assign occ_o     = wptr_q - rptr_q;
    assign m_data_o  = head_q;
    // A beat written into the slot that becomes the head bypasses storage.
    assign head_d = (push && wptr_q[AW-1:0] == rptr_d[AW-1:0]) ? s_data_i : mem_q[rptr_d[AW-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            head_q <= '0;
            rdy_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            head_q <= head_d;
            rdy_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= s_data_i;
    end
endmodule

// File: rtl/axi_chan_slice.sv
// axi_chan_slice: single AXI channel valid/ready stage built as wire, forward register,
// skid buffer or FIFO, with occupancy and completed-burst count.
module axi_chan_slice
    import axi_pkg::*;
#(
    parameter int PAYLOAD_W = 32,
    parameter int MODE      = 2,
    parameter int DEPTH     = 4,
    parameter int LAST_BIT  = -1,
    parameter int CNT_W     = 8,
    localparam int OCC_W    = $clog2(DEPTH) + 1
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [PAYLOAD_W-1:0] S_PAYLOAD,
    input  logic                 S_VALID,
    output logic                 S_READY,
    output logic [PAYLOAD_W-1:0] M_PAYLOAD,
    output logic                 M_VALID,
    input  logic                 M_READY,
    output logic [OCC_W-1:0]     OCCUPANCY,
    output logic [CNT_W-1:0]     BURST_CNT
);
    logic [CNT_W-1:0] cnt_q;

    if (MODE == int'(SLICE_BYPASS)) begin : g_bypass
        assign M_VALID   = S_VALID;
        assign S_READY   = M_READY;
        assign M_PAYLOAD = S_PAYLOAD;
        assign OCCUPANCY = '0;
    end else if (MODE == int'(SLICE_FWD)) begin : g_fwd
        fwd_state_e           state_q, state_d;
        logic [PAYLOAD_W-1:0] data_q, data_d;
        logic                 rdy_q, s_xfer, m_xfer;
        assign M_VALID   = state_q == FWD_FULL;
        assign S_READY   = rdy_q && (!M_VALID || M_READY);
        assign M_PAYLOAD = data_q;
        assign OCCUPANCY = {{(OCC_W-1){1'b0}}, M_VALID};
        assign s_xfer    = S_VALID && S_READY;
        assign m_xfer    = M_VALID && M_READY;
        always_comb begin
            state_d = s_xfer ? FWD_FULL : m_xfer ? FWD_EMPTY : state_q;
            data_d  = s_xfer ? S_PAYLOAD : data_q;
        end
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                state_q <= FWD_EMPTY;
                data_q  <= '0;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                data_q  <= data_d;
                rdy_q   <= 1'b1;
            end
        end
    end else if (MODE == int'(SLICE_SKID)) begin : g_skid
        skid_state_e          state_q, state_d;
        logic [PAYLOAD_W-1:0] main_q, main_d, skid_q, skid_d;
        logic                 rdy_q, s_xfer, m_xfer;
        assign M_VALID   = state_q != SKID_EMPTY;
        assign S_READY   = rdy_q;
        assign M_PAYLOAD = main_q;
        assign OCCUPANCY = state_q == SKID_TWO ? OCC_W'(2) : {{(OCC_W-1){1'b0}}, M_VALID};
        assign s_xfer    = S_VALID && rdy_q;
        assign m_xfer    = M_VALID && M_READY;
        always_comb begin
            state_d = state_q;
            main_d  = main_q;
            skid_d  = skid_q;
            case (state_q)
                SKID_EMPTY: if (s_xfer) begin
                    state_d = SKID_ONE;
                    main_d  = S_PAYLOAD;
                end
                SKID_ONE: begin
                    if (s_xfer && !m_xfer) begin
                        state_d = SKID_TWO;
                        skid_d  = S_PAYLOAD;
                    end else if (s_xfer) main_d = S_PAYLOAD;
                    else if (m_xfer) state_d = SKID_EMPTY;
                end
                SKID_TWO: if (m_xfer) begin
                    state_d = SKID_ONE;
                    main_d  = skid_q;
                end
                default: state_d = SKID_EMPTY;
            endcase
        end
        // Ready is registered: it looks one state ahead so the skid slot is never overrun.
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) begin
                state_q <= SKID_EMPTY;
                main_q  <= '0;
                skid_q  <= '0;
                rdy_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                main_q  <= main_d;
                skid_q  <= skid_d;
                rdy_q   <= state_d != SKID_TWO;
            end
        end
    end else begin : g_fifo
        axi_chan_fifo #(.W(PAYLOAD_W), .DEPTH(DEPTH)) u_fifo (
            .clk_i     (ACLK),
            .rst_i     (ARESET),
            .s_data_i  (S_PAYLOAD),
            .s_valid_i (S_VALID),
            .s_ready_o (S_READY),
            .m_data_o  (M_PAYLOAD),
            .m_valid_o (M_VALID),
            .m_ready_i (M_READY),
            .occ_o     (OCCUPANCY)
        );
    end

    if (LAST_BIT >= 0) begin : g_cnt
        always_ff @(posedge ACLK or posedge ARESET) begin
            if (ARESET) cnt_q <= '0;
            else if (M_VALID && M_READY && M_PAYLOAD[LAST_BIT]) cnt_q <= cnt_q + CNT_W'(1);
        end
    end else begin : g_no_cnt
        assign cnt_q = '0;
    end

    assign BURST_CNT = cnt_q;
endmodule
